// File: rtl/pe_pkg.sv
// Shared types and helpers for the systolic PE tile.
//   pe_mode_e  : packed-lane operand format (INT8 / INT16 / INT4 / reserved)
//   pe_state_e : control FSM states of the accumulator bank
//   lane_w()   : lane width in bits for a mode, 0 for the reserved mode
package pe_pkg;

    typedef enum logic [1:0] {
        INT8  = 2'd0,
        INT16 = 2'd1,
        INT4  = 2'd2,
        RSVD  = 2'd3
    } pe_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COMP  = 2'd2,
        DRAIN = 2'd3
    } pe_state_e;

    function automatic int unsigned lane_w(input pe_mode_e m);
        case (m)
            INT8:    return 8;
            INT16:   return 16;
            INT4:    return 4;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/systolic_pe_acc_if.sv
// Load/drain handshake bundle of the systolic PE tile.
//   load_req            : start a C preload (honoured in IDLE only)
//   c_valid/c_ready     : C-word handshake, c_data carries the word
//   drain_req           : request a drain of the accumulator bank
//   out_valid/out_ready : result handshake, out_data carries the word
// master = the side feeding C and consuming results, slave = the PE.
interface systolic_pe_acc_if #(
    parameter int ACC_W = 32
);
    logic             load_req;
    logic             c_valid;
    logic             c_ready;
    logic [ACC_W-1:0] c_data;
    logic             drain_req;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;

    modport master (
        output load_req, c_valid, c_data, drain_req, out_ready,
        input  c_ready, out_valid, out_data
    );

    modport slave (
        input  load_req, c_valid, c_data, drain_req, out_ready,
        output c_ready, out_valid, out_data
    );
endinterface

// File: rtl/pe_dot_lane.sv
// Combinational signed packed-lane dot product.
//   a, b : 32-bit operand words split into lanes of lane_w(mode) bits
//   mode : lane format; the reserved mode yields 0
//   sum  : sum of lane-wise signed products, sign-extended to OUT_W
module pe_dot_lane
    import pe_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic [31:0]             a,
    input  logic [31:0]             b,
    input  logic [1:0]              mode,
    output logic signed [OUT_W-1:0] sum
);
    // Internal width covers the widest possible sum (two 16x16 products).
    localparam int TW = (OUT_W > 40) ? OUT_W : 40;

    // Move lane idx to the top of the word, then arithmetic-shift it back
    // down so the lane's MSB becomes the sign.
    function automatic logic signed [TW-1:0] lane_sx(input logic [31:0] w,
                                                      input int unsigned idx,
                                                      input int unsigned lw);
        logic signed [31:0] t;
        t = signed'(w << (32 - (idx + 1) * lw));
        return TW'(t >>> (32 - lw));
    endfunction

    logic signed [TW-1:0] w_total;
    int unsigned          w_lw;

    always_comb begin
        w_total = '0;
        w_lw    = lane_w(pe_mode_e'(mode));
        for (int unsigned i = 0; i < 8; i++) begin
            if (w_lw != 0 && (i + 1) * w_lw <= 32)
                w_total = w_total + lane_sx(a, i, w_lw) * lane_sx(b, i, w_lw);
        end
    end

    assign sum = w_total[OUT_W-1:0];

endmodule

// File: rtl/systolic_pe_acc.sv
// Systolic processing element with a DEPTH-entry accumulator bank.
//   clk, rst             : clock, synchronous active-high reset
//   en_left/a_left       : A operand in, forwarded to en_right/a_right
//   en_up/b_up           : B operand in, forwarded to en_down/b_down
//   mode                 : lane format of the dot product
//   busy                 : FSM is not IDLE
//   err                  : sticky protocol error
//   bus (slave)          : C preload and result drain handshakes
// A fire (both operands valid in COMP) computes a packed-lane dot product
// that is added into bank[ptr] two edges later; ptr walks the bank cyclically.
module systolic_pe_acc
    import pe_pkg::*;
#(
    parameter int ID    = 0,
    parameter int DEPTH = 4,
    parameter int ACC_W = 32,
    parameter bit SAT   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_left,
    input  logic              en_up,
    input  logic [31:0]       a_left,
    input  logic [31:0]       b_up,
    output logic              en_right,
    output logic              en_down,
    output logic [31:0]       a_right,
    output logic [31:0]       b_down,
    input  logic [1:0]        mode,
    output logic              busy,
    output logic              err,
    systolic_pe_acc_if.slave  bus
);
    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] x,
                                                         input logic signed [ACC_W-1:0] y);
        logic signed [ACC_W:0] s;
        s = {x[ACC_W-1], x} + {y[ACC_W-1], y};
        // The extra top bit disagrees with the sign bit exactly on overflow.
        if (SAT && (s[ACC_W] != s[ACC_W-1]))
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
    endfunction

    pe_state_e               r_state;
    logic [PTR_W-1:0]        r_ptr;
    logic signed [ACC_W-1:0] r_bank [DEPTH];
    logic signed [ACC_W-1:0] r_sum_p1;
    logic [PTR_W-1:0]        r_ptr_p1;
    logic                    r_vld_p1;
    logic                    r_drain_pend;
    logic                    r_err;
    logic                    r_busy;
    logic                    r_c_ready;
    logic                    r_out_valid;
    logic [ACC_W-1:0]        r_out_data;
    logic                    r_en_right;
    logic                    r_en_down;
    logic [31:0]             r_a_right;
    logic [31:0]             r_b_down;

    logic                    w_fire;
    logic signed [ACC_W-1:0] w_sum;
    logic [PTR_W-1:0]        w_ptr_nxt;

    assign w_fire    = en_left && en_up && (r_state == COMP);
    assign w_ptr_nxt = r_ptr + 1'b1;

    pe_dot_lane #(.OUT_W(ACC_W)) u_dot (
        .a    (a_left),
        .b    (b_up),
        .mode (mode),
        .sum  (w_sum)
    );

    // Operand forwarding: one hop per cycle regardless of state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_right <= 1'b0;
            r_en_down  <= 1'b0;
            r_a_right  <= '0;
            r_b_down   <= '0;
        end else begin
            r_en_right <= en_left;
            r_en_down  <= en_up;
            r_a_right  <= a_left;
            r_b_down   <= b_up;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_ptr_p1     <= '0;
            r_vld_p1     <= 1'b0;
            r_drain_pend <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_c_ready    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            for (int k = 0; k < DEPTH; k++)
                r_bank[k] <= '0;
        end else begin
            if ((en_left ^ en_up) ||
                (en_left && en_up && r_state != COMP) ||
                (w_fire && mode == RSVD))
                r_err <= 1'b1;

            // ---- stage 1: capture dot product and target entry ----
            r_vld_p1 <= w_fire;
            if (w_fire) begin
                r_sum_p1 <= w_sum;
                r_ptr_p1 <= r_ptr;
            end

            // ---- stage 2: accumulate into the bank ----
            if (r_vld_p1)
                r_bank[r_ptr_p1] <= acc_add(r_bank[r_ptr_p1], r_sum_p1);

            case (r_state)
                IDLE: begin
                    if (bus.load_req) begin
                        r_state   <= LOAD;
                        r_ptr     <= '0;
                        r_c_ready <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.c_valid && r_c_ready) begin
                        r_bank[r_ptr] <= bus.c_data;
                        r_ptr         <= w_ptr_nxt;
                        if (r_ptr == PTR_LAST) begin
                            r_state   <= COMP;
                            r_ptr     <= '0;
                            r_c_ready <= 1'b0;
                        end
                    end
                end
                COMP: begin
                    if (w_fire)
                        r_ptr <= w_ptr_nxt;
                    if (bus.drain_req)
                        r_drain_pend <= 1'b1;
                    // Leave only once the accumulate pipe is empty, so the
                    // bank read for draining sees every accepted fire.
                    if (r_drain_pend && !r_vld_p1 && !w_fire) begin
                        r_state     <= DRAIN;
                        r_ptr       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_bank[0];
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        r_ptr      <= w_ptr_nxt;
                        r_out_data <= r_bank[w_ptr_nxt];
                        if (r_ptr == PTR_LAST) begin
                            r_state      <= IDLE;
                            r_out_valid  <= 1'b0;
                            r_drain_pend <= 1'b0;
                            r_busy       <= 1'b0;
`ifndef SYNTHESIS
                            for (int k = 0; k < DEPTH; k++)
                                $display("PE%0d bank[%0d] = %0h", ID, k, r_bank[k]);
`endif
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign en_right      = r_en_right;
    assign en_down       = r_en_down;
    assign a_right       = r_a_right;
    assign b_down        = r_b_down;
    assign busy          = r_busy;
    assign err           = r_err;
    assign bus.c_ready   = r_c_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

endmodule

// File: tb/tb_systolic_pe_acc.sv
// Scoreboard bench: two PEs (saturating and wrapping) share all stimulus;
// a behavioural model predicts bank contents, expected words are queued at
// drain time and popped as each result transfer is observed.
module tb_systolic_pe_acc;
    import pe_pkg::*;

    localparam int DEPTH = 4;
    localparam int ACC_W = 32;

    logic clk;
    logic rst;
    logic en_left, en_up;
    logic [31:0] a_left, b_up;
    logic [1:0]  mode;
    logic load_req, c_valid, drain_req, out_ready;
    logic [ACC_W-1:0] c_data;

    logic en_right_s, en_down_s, busy_s, err_s;
    logic en_right_w, en_down_w, busy_w, err_w;
    logic [31:0] a_right_s, b_down_s, a_right_w, b_down_w;

    systolic_pe_acc_if #(.ACC_W(ACC_W)) bus_s ();
    systolic_pe_acc_if #(.ACC_W(ACC_W)) bus_w ();

    assign bus_s.load_req  = load_req;
    assign bus_s.c_valid   = c_valid;
    assign bus_s.c_data    = c_data;
    assign bus_s.drain_req = drain_req;
    assign bus_s.out_ready = out_ready;
    assign bus_w.load_req  = load_req;
    assign bus_w.c_valid   = c_valid;
    assign bus_w.c_data    = c_data;
    assign bus_w.drain_req = drain_req;
    assign bus_w.out_ready = out_ready;

    systolic_pe_acc #(.ID(0), .DEPTH(DEPTH), .ACC_W(ACC_W), .SAT(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en_left(en_left), .en_up(en_up),
        .a_left(a_left), .b_up(b_up), .en_right(en_right_s), .en_down(en_down_s),
        .a_right(a_right_s), .b_down(b_down_s), .mode(mode),
        .busy(busy_s), .err(err_s), .bus(bus_s)
    );

    systolic_pe_acc #(.ID(1), .DEPTH(DEPTH), .ACC_W(ACC_W), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en_left(en_left), .en_up(en_up),
        .a_left(a_left), .b_up(b_up), .en_right(en_right_w), .en_down(en_down_w),
        .a_right(a_right_w), .b_down(b_down_w), .mode(mode),
        .busy(busy_w), .err(err_w), .bus(bus_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    longint m_bank_s [DEPTH];
    longint m_bank_w [DEPTH];
    int     m_ptr;
    logic [31:0] q_s [$];
    logic [31:0] q_w [$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic longint dot_ref(input logic [31:0] a, input logic [31:0] b,
                                       input logic [1:0] m);
        longint s = 0;
        case (m)
            2'd0: for (int i = 0; i < 4; i++)
                      s += longint'($signed(a[i*8 +: 8])) * longint'($signed(b[i*8 +: 8]));
            2'd1: for (int i = 0; i < 2; i++)
                      s += longint'($signed(a[i*16 +: 16])) * longint'($signed(b[i*16 +: 16]));
            2'd2: for (int i = 0; i < 8; i++)
                      s += longint'($signed(a[i*4 +: 4])) * longint'($signed(b[i*4 +: 4]));
            default: s = 0;
        endcase
        return s;
    endfunction

    function automatic longint wrap32(input longint v);
        logic [31:0] t;
        t = v[31:0];
        return longint'($signed(t));
    endfunction

    function automatic longint sat32(input longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    task automatic model_fire(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
        longint s;
        s = dot_ref(a, b, m);
        m_bank_s[m_ptr] = sat32(m_bank_s[m_ptr] + s);
        m_bank_w[m_ptr] = wrap32(m_bank_w[m_ptr] + s);
        m_ptr = (m_ptr + 1) % DEPTH;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic load_c(input longint c0, input longint c1, input longint c2, input longint c3);
        longint cv [DEPTH];
        cv = '{c0, c1, c2, c3};
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            check_eq($sformatf("c_ready[%0d]", i), 32'(bus_s.c_ready), 32'd1);
            c_valid     = 1'b1;
            c_data      = cv[i][31:0];
            m_bank_s[i] = cv[i];
            m_bank_w[i] = cv[i];
            @(posedge clk); #1;
        end
        c_valid = 1'b0;
        m_ptr   = 0;
        check_eq("c_ready_done", 32'(bus_s.c_ready), 32'd0);
    endtask

    task automatic fire(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                        input bit last, input bit with_drain);
        en_left   = 1'b1;
        en_up     = 1'b1;
        a_left    = a;
        b_up      = b;
        mode      = m;
        drain_req = with_drain;
        model_fire(a, b, m);
        @(posedge clk); #1;
        drain_req = 1'b0;
        if (last) begin
            en_left = 1'b0;
            en_up   = 1'b0;
        end
    endtask

    task automatic drain(input string name, input bit req, input int stall_at);
        int n      = 0;
        int stalls = 0;
        int cyc    = 0;
        for (int i = 0; i < DEPTH; i++) begin
            q_s.push_back(m_bank_s[i][31:0]);
            q_w.push_back(m_bank_w[i][31:0]);
        end
        if (req) begin
            drain_req = 1'b1;
            @(posedge clk); #1;
            drain_req = 1'b0;
        end
        while (n < DEPTH && cyc < 40) begin
            if (bus_s.out_valid) begin
                if (n == stall_at && stalls < 3) begin
                    out_ready = 1'b0;
                    check_eq($sformatf("%s_held%0d", name, stalls), bus_s.out_data, q_s[0]);
                    stalls++;
                end else begin
                    out_ready = 1'b1;
                    check_eq($sformatf("%s_sat[%0d]", name, n), bus_s.out_data, q_s.pop_front());
                    check_eq($sformatf("%s_wrap[%0d]", name, n), bus_w.out_data, q_w.pop_front());
                    n++;
                end
            end else begin
                out_ready = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        q_s.delete();
        q_w.delete();
        check_eq({name, "_count"}, 32'(n), 32'(DEPTH));
        check_eq({name, "_busy_idle"}, 32'(busy_s), 32'd0);
        check_eq({name, "_valid_idle"}, 32'(bus_s.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b1; en_left = 1'b0; en_up = 1'b0; a_left = '0; b_up = '0; mode = 2'd0;
        load_req = 1'b0; c_valid = 1'b0; c_data = '0; drain_req = 1'b0; out_ready = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_bank_s[i] = 0;
            m_bank_w[i] = 0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_en_right", 32'(en_right_s), 32'd0);
        check_eq("rst_a_right", a_right_s, 32'd0);
        check_eq("rst_busy", 32'(busy_s), 32'd0);
        check_eq("rst_err", 32'(err_s), 32'd0);
        check_eq("rst_out_valid", 32'(bus_s.out_valid), 32'd0);
        check_eq("rst_c_ready", 32'(bus_s.c_ready), 32'd0);
        rst = 1'b0;

        // Forwarding in IDLE with only A valid
        en_left = 1'b1; a_left = 32'h12345678; b_up = 32'hCAFEF00D;
        @(posedge clk); #1;
        en_left = 1'b0;
        check_eq("fwd_a_right", a_right_s, 32'h12345678);
        check_eq("fwd_en_right", 32'(en_right_s), 32'd1);
        check_eq("fwd_b_down", b_down_w, 32'hCAFEF00D);
        check_eq("fwd_en_down", 32'(en_down_s), 32'd0);
        check_eq("fwd_err", 32'(err_s), 32'd1);
        @(posedge clk); #1;
        check_eq("fwd_en_right_off", 32'(en_right_s), 32'd0);
        do_reset();

        // Lane modes, last fire overlapping the drain request
        load_c(0, 0, 0, 0);
        fire(32'h01020304, 32'h05060708, 2'd0, 1'b0, 1'b0);
        fire(32'hFFFFFFFF, 32'h01010101, 2'd0, 1'b0, 1'b0);
        fire(32'h11111111, 32'hFFFFFFFF, 2'd2, 1'b0, 1'b0);
        fire(32'h7FFF7FFF, 32'h7FFF7FFF, 2'd1, 1'b1, 1'b1);
        drain("lanes", 1'b0, -1);
        check_eq("lanes_err", 32'(err_s), 32'd0);

        // Pointer wrap: two passes over the bank, with output backpressure
        load_c(10, 20, 30, 40);
        for (int i = 0; i < 8; i++)
            fire(32'h00000001, 32'h00000001, 2'd0, i == 7, 1'b0);
        drain("wrap", 1'b1, 1);

        // Positive/negative saturation and a reserved-mode fire
        load_c(64'sh7FFFFFF0, 0, longint'($signed(32'h80000010)), 5);
        fire(32'h01020304, 32'h05060708, 2'd0, 1'b0, 1'b0);
        fire(32'h01010101, 32'h01010101, 2'd3, 1'b0, 1'b0);
        fire(32'h7F7F7F7F, 32'h80808080, 2'd0, 1'b1, 1'b0);
        drain("sat", 1'b1, -1);
        check_eq("rsvd_err_s", 32'(err_s), 32'd1);
        check_eq("rsvd_err_w", 32'(err_w), 32'd1);

        // Reset in the middle of a drain
        do_reset();
        load_c(1, 2, 3, 4);
        drain_req = 1'b1;
        @(posedge clk); #1;
        drain_req = 1'b0;
        cyc = 0;
        while (!bus_s.out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("mid_drain_valid", 32'(bus_s.out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("mid_rst_valid", 32'(bus_s.out_valid), 32'd0);
        check_eq("mid_rst_busy", 32'(busy_s), 32'd0);
        check_eq("mid_rst_data", bus_s.out_data, 32'd0);
        check_eq("mid_rst_err", 32'(err_s), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
